// File: rtl/stream_capture_burst.sv
// Snoops a non-backpressuring AXI-Stream into a first-word-fall-through FIFO and
// writes it to memory as incrementing AXI4 bursts inside a programmable ring buffer.
module stream_capture_burst #(
  parameter int DATA_WIDTH      = 512,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 6,
  parameter int FIFO_DEPTH      = 128,
  parameter int BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [STRB_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           buf_beats,
  input  logic [31:0]           capture_beats,
  input  logic                  wrap_en,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  error,
  output logic [31:0]           beats_captured,
  output logic [31:0]           drop_count,
  output logic [1:0]            dbg_cap_state,
  output logic [1:0]            dbg_wr_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both
  // high; a raised valid holds its payload until then. The stream side has no
  // backpressure, so tready only reflects reset.

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FIFO_W = DATA_WIDTH + STRB_WIDTH;

  localparam logic [1:0] CAP_IDLE    = 2'd0;
  localparam logic [1:0] CAP_CAPTURE = 2'd1;
  localparam logic [1:0] CAP_DRAIN   = 2'd2;
  localparam logic [1:0] CAP_DONE    = 2'd3;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;

  logic [1:0]            cap_state, wr_state;
  logic [FIFO_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [FIFO_W-1:0]     fifo_rd;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      fifo_level;
  logic                  fifo_full, push, pop, drop, last_push, start_ok;
  logic [ADDR_WIDTH-1:0] base_q, ring_end_q, wr_addr, next_addr, addr_step;
  logic [31:0]           eff_len, eff_len_q;
  logic [8:0]            burst_len_q, beat_cnt, issue_len;
  logic [OUT_W-1:0]      outstanding;
  logic                  level_ge_burst, issue, aw_hs, drain_done;
  logic                  unused_tlast;

  assign unused_tlast = s_axis_tlast;

  assign start_ok  = start && (cap_state == CAP_IDLE || cap_state == CAP_DONE);
  assign eff_len   = (wrap_en || capture_beats < buf_beats) ? capture_beats : buf_beats;
  assign fifo_full = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign pop       = (wr_state == W_DATA) && m_axi_wready;
  // A full FIFO still takes a beat when the write side pops in the same cycle.
  assign push      = (cap_state == CAP_CAPTURE) && s_axis_tvalid && (!fifo_full || pop);
  assign drop      = (cap_state == CAP_CAPTURE) && s_axis_tvalid && fifo_full && !pop;
  assign last_push = push && (beats_captured + 32'd1 == eff_len_q);
  assign fifo_rd   = fifo_mem[rd_ptr];

  assign level_ge_burst = (32'(fifo_level) >= 32'(BURST_LEN));
  assign issue_len      = level_ge_burst ? 9'(BURST_LEN) : 9'(fifo_level);
  assign issue = (wr_state == W_IDLE) && (outstanding < OUT_W'(MAX_OUTSTANDING)) &&
                 (level_ge_burst || (cap_state == CAP_DRAIN && fifo_level != '0));
  assign aw_hs      = (wr_state == W_ADDR) && m_axi_awready;
  assign drain_done = (fifo_level == '0) && (wr_state == W_IDLE) && (outstanding == '0);
  assign addr_step  = ADDR_WIDTH'(32'(burst_len_q) * 32'(STRB_WIDTH));
  assign next_addr  = wr_addr + addr_step;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {s_axis_tkeep, s_axis_tdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_state      <= CAP_IDLE;
      beats_captured <= '0;
      drop_count     <= '0;
      overflow       <= 1'b0;
      base_q         <= '0;
      ring_end_q     <= '0;
      eff_len_q      <= '0;
    end else begin
      case (cap_state)
        CAP_IDLE, CAP_DONE: begin
          if (start_ok) begin
            cap_state      <= CAP_CAPTURE;
            beats_captured <= '0;
            drop_count     <= '0;
            overflow       <= 1'b0;
            base_q         <= base_addr;
            ring_end_q     <= base_addr + ADDR_WIDTH'(buf_beats * 32'(STRB_WIDTH));
            eff_len_q      <= eff_len;
          end
        end
        CAP_CAPTURE: begin
          if (push) beats_captured <= beats_captured + 32'd1;
          if (drop) begin
            drop_count <= drop_count + 32'd1;
            overflow   <= 1'b1;
          end
          if (last_push || stop) cap_state <= CAP_DRAIN;
        end
        CAP_DRAIN: begin
          if (drain_done) cap_state <= CAP_DONE;
        end
        default: cap_state <= CAP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      error <= 1'b0;
    end else if (start_ok) begin
      error <= 1'b0;
    end else if (m_axi_bvalid && m_axi_bresp != 2'b00) begin
      error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state    <= W_IDLE;
      wr_addr     <= '0;
      burst_len_q <= '0;
      beat_cnt    <= '0;
    end else begin
      if (start_ok) wr_addr <= base_addr;
      case (wr_state)
        W_IDLE: begin
          if (issue) begin
            burst_len_q <= issue_len;
            beat_cnt    <= issue_len;
            wr_state    <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (m_axi_awready) wr_state <= W_DATA;
        end
        W_DATA: begin
          if (m_axi_wready) begin
            beat_cnt <= beat_cnt - 9'd1;
            if (beat_cnt == 9'd1) begin
              wr_state <= W_IDLE;
              // Ring end wraps to base; in one-shot mode this only meets the end of capture.
              wr_addr  <= (next_addr == ring_end_q) ? base_q : next_addr;
            end
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({aw_hs, m_axi_bvalid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign s_axis_tready = !rst;
  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = wr_addr;
  assign m_axi_awlen   = 8'(burst_len_q - 9'd1);
  assign m_axi_awsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awvalid = (wr_state == W_ADDR);
  assign m_axi_wdata   = fifo_rd[DATA_WIDTH-1:0];
  assign m_axi_wstrb   = fifo_rd[FIFO_W-1:DATA_WIDTH];
  assign m_axi_wlast   = (wr_state == W_DATA) && (beat_cnt == 9'd1);
  assign m_axi_wvalid  = (wr_state == W_DATA);
  assign m_axi_bready  = 1'b1;

  assign busy          = (cap_state == CAP_CAPTURE) || (cap_state == CAP_DRAIN);
  assign done          = (cap_state == CAP_DONE);
  assign dbg_cap_state = cap_state;
  assign dbg_wr_state  = wr_state;

endmodule

// File: tb/tb_stream_capture_burst.sv
// Directed bench for stream_capture_burst: expected AW/W traffic is queued when a
// capture is set up, and a monitor pops and compares on every AW and W handshake.
module tb_stream_capture_burst;

  localparam int DW = 512;
  localparam int SW = DW / 8;
  localparam int AW = 32;
  localparam int IW = 6;
  localparam int WE = DW + SW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [SW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [IW-1:0] m_axi_awid;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awlock;
  logic [3:0]    m_axi_awcache;
  logic [2:0]    m_axi_awprot;
  logic          m_axi_awvalid;
  logic          m_axi_awready = 1'b1;
  logic [DW-1:0] m_axi_wdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_wvalid;
  logic          m_axi_wready = 1'b1;
  logic [1:0]    m_axi_bresp = 2'b00;
  logic          m_axi_bvalid = 1'b0;
  logic          m_axi_bready;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [31:0]   buf_beats = '0;
  logic [31:0]   capture_beats = '0;
  logic          wrap_en = 1'b0;
  logic          busy, done, overflow, error;
  logic [31:0]   beats_captured, drop_count;
  logic [1:0]    dbg_cap_state, dbg_wr_state;

  always #5 clk = ~clk;

  stream_capture_burst dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .start(start), .stop(stop), .base_addr(base_addr), .buf_beats(buf_beats),
    .capture_beats(capture_beats), .wrap_en(wrap_en),
    .busy(busy), .done(done), .overflow(overflow), .error(error),
    .beats_captured(beats_captured), .drop_count(drop_count),
    .dbg_cap_state(dbg_cap_state), .dbg_wr_state(dbg_wr_state)
  );

  int checks = 0;
  int failures = 0;
  logic [AW+7:0] exp_aw_q[$];
  logic [WE-1:0] exp_w_q[$];
  logic [AW+7:0] mon_aw_exp;
  logic [WE-1:0] mon_w_exp;
  int b_owed = 0;
  int b_idx = 0;
  int err_idx = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [15:0] seed, input int i);
    logic [31:0] w;
    w = {seed, 16'(i)};
    return {16{w}};
  endfunction

  function automatic logic [SW-1:0] beat_keep(input int i);
    logic [7:0] b;
    b = 8'(i * 3 + 1);
    return {56'hFF_FFFF_FFFF_FFFF, b};
  endfunction

  task automatic expect_burst(input logic [AW-1:0] addr, input int len, input int first,
                              input logic [15:0] seed);
    exp_aw_q.push_back({addr, 8'(len - 1)});
    for (int j = 0; j < len; j++)
      exp_w_q.push_back({beat_data(seed, first + j), beat_keep(first + j), (j == len - 1)});
  endtask

  // Monitor: compares every AW / W handshake against the expected queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axi_awvalid && m_axi_awready) begin
        check("aw_attr", {m_axi_awid, m_axi_awsize, m_axi_awburst}, {6'd0, 3'd6, 2'd1});
        if (exp_aw_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL aw_unexpected got addr=%0h len=%0d required none", m_axi_awaddr, m_axi_awlen);
        end else begin
          mon_aw_exp = exp_aw_q.pop_front();
          check("aw_addr_len", {m_axi_awaddr, m_axi_awlen}, mon_aw_exp);
        end
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (m_axi_wlast) b_owed++;
        checks++;
        if (exp_w_q.size() == 0) begin
          failures++;
          $display("FAIL w_unexpected got data=%0h required none", m_axi_wdata[31:0]);
        end else begin
          mon_w_exp = exp_w_q.pop_front();
          if ({m_axi_wdata, m_axi_wstrb, m_axi_wlast} !== mon_w_exp) begin
            failures++;
            $display("FAIL w_beat got=%0h required=%0h", {m_axi_wdata, m_axi_wstrb, m_axi_wlast}, mon_w_exp);
          end
        end
      end
    end
  end

  // B responder: one response per completed W burst, bresp=SLVERR on burst err_idx.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (m_axi_bvalid && m_axi_bready) begin
        b_owed--;
        b_idx++;
      end
      m_axi_bvalid = (b_owed > 0);
      m_axi_bresp  = (b_idx == err_idx) ? 2'b10 : 2'b00;
    end
  end

  task automatic start_capture(input logic [AW-1:0] base, input int bufb, input int capb,
                               input logic wrap, input int err);
    @(posedge clk); #1;
    base_addr = base; buf_beats = 32'(bufb); capture_beats = 32'(capb); wrap_en = wrap;
    err_idx = err; b_idx = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    check("beats_cleared", beats_captured, 0);
    check("overflow_cleared", overflow, 0);
    check("error_cleared", error, 0);
  endtask

  task automatic drive_beats(input logic [15:0] seed, input int n, input int stop_at,
                             input int junk_start_at);
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = beat_data(seed, i);
      s_axis_tkeep  = beat_keep(i);
      s_axis_tlast  = (i == n - 1);
      stop          = (i == stop_at);
      start         = (i == junk_start_at);
      if (i == junk_start_at) base_addr = 32'hDEAD_0000;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; stop = 1'b0; start = 1'b0;
  endtask

  task automatic end_checks(input string name, input int exp_beats, input int exp_drops,
                            input logic exp_ovf, input logic exp_err);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_done_timeout got done=0 required done=1", name);
    end
    check({name, "_b_pending_at_done"}, 64'(b_owed), 0);
    check({name, "_aw_left"}, 64'(exp_aw_q.size()), 0);
    check({name, "_w_left"}, 64'(exp_w_q.size()), 0);
    check({name, "_beats"}, beats_captured, 64'(exp_beats));
    check({name, "_drops"}, drop_count, 64'(exp_drops));
    check({name, "_overflow"}, overflow, 64'(exp_ovf));
    check({name, "_error"}, error, 64'(exp_err));
    check({name, "_busy"}, busy, 0);
    check({name, "_states"}, {dbg_cap_state, dbg_wr_state}, 4'b1100);
    exp_aw_q.delete();
    exp_w_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", s_axis_tready, 0);
    check("rst_valids", {m_axi_awvalid, m_axi_wvalid}, 0);
    check("rst_status", {busy, done, overflow, error}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("tready_after_rst", s_axis_tready, 1);
    check("bready", m_axi_bready, 1);
    check("idle_counters", {beats_captured, drop_count}, 0);
    check("idle_states", {dbg_cap_state, dbg_wr_state}, 0);

    // One-shot, 64 beats: four full bursts
    for (int k = 0; k < 4; k++) expect_burst(32'h1000_0000 + 32'(k * 'h400), 16, 16 * k, 16'h0001);
    start_capture(32'h1000_0000, 256, 64, 1'b0, -1);
    drive_beats(16'h0001, 64, -1, -1);
    end_checks("oneshot64", 64, 0, 1'b0, 1'b0);

    // 20 beats: full burst then DRAIN flush of 4; a start while busy is ignored
    expect_burst(32'h2000_0000, 16, 0, 16'h0002);
    expect_burst(32'h2000_0400, 4, 16, 16'h0002);
    start_capture(32'h2000_0000, 256, 20, 1'b0, -1);
    drive_beats(16'h0002, 20, -1, 10);
    end_checks("flush20", 20, 0, 1'b0, 1'b0);

    // Ring mode: 32-beat ring, 80 beats
    for (int k = 0; k < 5; k++) expect_burst(32'h3000_0000 + 32'((k % 2) * 'h400), 16, 16 * k, 16'h0003);
    start_capture(32'h3000_0000, 32, 80, 1'b1, -1);
    drive_beats(16'h0003, 80, -1, -1);
    end_checks("wrap80", 80, 0, 1'b0, 1'b0);

    // One-shot length clipped to the ring size
    expect_burst(32'h4000_0000, 16, 0, 16'h0004);
    expect_burst(32'h4000_0400, 16, 16, 16'h0004);
    start_capture(32'h4000_0000, 32, 300, 1'b0, -1);
    drive_beats(16'h0004, 40, -1, -1);
    end_checks("clip32", 32, 0, 1'b0, 1'b0);

    // SLVERR on the second burst: error sticky, capture completes
    for (int k = 0; k < 4; k++) expect_burst(32'h5000_0000 + 32'(k * 'h400), 16, 16 * k, 16'h0005);
    start_capture(32'h5000_0000, 256, 64, 1'b0, 1);
    drive_beats(16'h0005, 64, -1, -1);
    end_checks("bresp_err", 64, 0, 1'b0, 1'b1);

    // Stop together with beat 24: 25 beats kept, first burst finishes, then 9-beat flush
    expect_burst(32'h6000_0000, 16, 0, 16'h0006);
    expect_burst(32'h6000_0400, 9, 16, 16'h0006);
    start_capture(32'h6000_0000, 256, 100, 1'b0, -1);
    drive_beats(16'h0006, 40, 24, -1);
    end_checks("stop25", 25, 0, 1'b0, 1'b0);

    // AW stalled: FIFO keeps the first 128 beats, 172 of 300 are dropped
    for (int k = 0; k < 8; k++) expect_burst(32'h7000_0000 + 32'(k * 'h400), 16, 16 * k, 16'h0007);
    m_axi_awready = 1'b0;
    start_capture(32'h7000_0000, 1024, 1000, 1'b0, -1);
    drive_beats(16'h0007, 300, -1, -1);
    repeat (200) @(posedge clk);
    #1;
    check("stall_awvalid_held", m_axi_awvalid, 1);
    check("stall_beats", beats_captured, 128);
    check("stall_drops", drop_count, 172);
    check("stall_overflow", overflow, 1);
    m_axi_awready = 1'b1;
    for (int n = 0; n < 2000 && exp_w_q.size() != 0; n++) @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    end_checks("overflow", 128, 172, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog got=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
